ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer for the single-port memoram (32x8).
//  Serialises read/write commands from requesters A and B onto one address/data/wren
//  port, counts out the RAM read latency, returns read data and pulses per-requester done.
//  Sits between user logic (switch/FSM front-ends) and memoram; q drives the shared rdata bus.
// PARAMETERS
//  AW          5  address width (memoram depth 2**AW)
//  DW          8  data width
//  RD_LATENCY  1  cycles from the edge sampling mem_address to valid mem_q; legal 1..4
// PORTS
//  clock        in   1   single system clock, rising edge
//  reset        in   1   synchronous, active-high
//  a_req        in   1   A command request, held until a_done
//  a_we         in   1   A: 1=write, 0=read; stable while a_req
//  a_addr       in   AW  A address; stable while a_req
//  a_wdata      in   DW  A write data; stable while a_req
//  a_gnt        out  1   A owns the RAM (ISSUE..RESP)
//  a_done       out  1   one-cycle pulse: A command complete
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_done      same as A, for requester B
//  rdata        out  DW  read data; valid when a_done/b_done pulses after a read
//  busy         out  1   state != IDLE
//  mem_address  out  AW  to memoram .address
//  mem_data     out  DW  to memoram .data
//  mem_wren     out  1   to memoram .wren
//  mem_q        in   DW  from memoram .q
// BEHAVIOUR
//  Reset: state=IDLE; a_gnt=b_gnt=a_done=b_done=busy=mem_wren=0; rdata=0; mem_address=0;
//   mem_data=0; priority pointer=B-last (A wins the first tie).
//  FSM: IDLE -> ISSUE -> (write) RESP -> IDLE; (read) ISSUE -> WAIT x RD_LATENCY -> RESP -> IDLE.
//  IDLE: sample reqs. One req -> grant it. Both -> grant the one not served last.
//   Latch we/addr/wdata/owner into the command register; go ISSUE. No req -> stay IDLE.
//  ISSUE (1 cycle): mem_address=cmd addr, mem_data=cmd wdata, mem_wren=cmd we.
//  WAIT (RD_LATENCY cycles, down-counter): mem_address held, mem_wren=0;
//   rdata<=mem_q at the end of the last WAIT cycle.
//  RESP (1 cycle): owner done=1; mem_wren=0; pointer<=owner; next IDLE.
//  mem_* are driven only from the command register and state; mem_wren=1 only in ISSUE.
//  gnt is high for the owner from ISSUE through RESP inclusive; never both high.
//  Latency (req seen in IDLE at cycle 0): write done in cycle 2; read done in cycle
//   2+RD_LATENCY (cycle 3 at default).
//  Requester rule: req must be low in the cycle after its done pulse; if it is still
//   high it is taken as a new command (legal back-to-back, round-robin still applies).
//  Input changes while granted are ignored (command already latched).
//  rdata holds its last read value across writes and idle cycles.
//  Reset mid-operation: any state -> IDLE on the reset edge; no done pulse for the
//   aborted command. A write in ISSUE at the reset edge may still commit in RAM.
//  Both reqs held continuously -> grants strictly alternate A,B,A,B (no starvation).
// TESTING
//  1 Reset, A write addr=3 data=8'h5A -> mem_wren=1 in cycle 1 only; a_done in cycle 2; b_gnt=0.
//  2 A read addr=3 after 1 -> mem_wren=0; a_done in cycle 3; rdata=8'h5A on the pulse.
//  3 A write 7<=8'h11 and B write 9<=8'h22 in the same IDLE cycle -> A served first,
//    then B; then reads return 8'h11 @7 and 8'h22 @9.
//  4 a_req and b_req both held high for 8 commands -> gnt order A,B,A,B,...; never both gnt high.
//  5 reset asserted during WAIT of a B read -> next cycle IDLE, all outputs 0, no b_done;
//    a new A read then completes normally.
//  6 RD_LATENCY=3 build, read addr=0 -> a_done in cycle 5; rdata equals the RAM contents.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//  Bundles the two requester command ports, the shared read-data/status
//  outputs and the single-port RAM connection of ram_arbiter.
//  Ports (all signals, directions seen from the arbiter / slave modport):
//    a_req, a_we, a_addr, a_wdata   in   requester A command
//    a_gnt, a_done                  out  requester A grant / completion pulse
//    b_req, b_we, b_addr, b_wdata   in   requester B command
//    b_gnt, b_done                  out  requester B grant / completion pulse
//    rdata                          out  last read data
//    busy                           out  arbiter not idle
//    mem_address, mem_data, mem_wren out to memoram
//    mem_q                          in   from memoram
//  modport slave  : the arbiter
//  modport master : requester/RAM side (user logic or a testbench)
interface ram_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_done;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_done;

  logic [DW-1:0] rdata;
  logic          busy;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_done,
    output rdata, busy,
    output mem_address, mem_data, mem_wren,
    input  mem_q
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_done,
    input  rdata, busy,
    input  mem_address, mem_data, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//  Two-requester round-robin arbiter/sequencer for a single-port RAM.
//  A command from A or B is latched in IDLE, presented to the RAM in ISSUE,
//  reads wait RD_LATENCY cycles for mem_q, and RESP pulses the owner's done.
//  Ports:
//    clock   in   rising-edge system clock
//    reset   in   synchronous active-high reset
//    bus     ram_arbiter_if.slave  requester commands, grants, done pulses,
//            rdata, busy and the memoram address/data/wren/q connection
//  Parameters: AW address width, DW data width (must match the interface),
//              RD_LATENCY RAM read latency in cycles, legal 1..4.
module ram_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int RD_LATENCY = 1
) (
  input logic          clock,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_cnt;
  logic [1:0]    w_cnt_next;

  // Command register: owner 0 = A, 1 = B.
  logic          r_cmd_we;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;
  logic          r_cmd_owner;

  // Round-robin pointer: 1 means B was served last, so A wins a tie.
  logic          r_last_b;
  logic [DW-1:0] r_rdata;

  logic          w_load;
  logic          w_owner_sel;
  logic          w_rdata_load;
  logic          w_ptr_load;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_owner_sel  = 1'b0;
    w_rdata_load = 1'b0;
    w_ptr_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          w_load = 1'b1;
          // B wins when it is alone, or on a tie when A was served last.
          w_owner_sel  = bus.b_req && (!bus.a_req || !r_last_b);
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cmd_we) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_WAIT;
          w_cnt_next   = 2'(RD_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_rdata_load = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      S_RESP: begin
        w_ptr_load   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_owner <= 1'b0;
      r_last_b    <= 1'b1;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_cmd_owner <= w_owner_sel;
        r_cmd_we    <= w_owner_sel ? bus.b_we    : bus.a_we;
        r_cmd_addr  <= w_owner_sel ? bus.b_addr  : bus.a_addr;
        r_cmd_wdata <= w_owner_sel ? bus.b_wdata : bus.a_wdata;
      end
      if (w_rdata_load) begin
        r_rdata <= bus.mem_q;
      end
      if (w_ptr_load) begin
        r_last_b <= r_cmd_owner;
      end
    end
  end

  // RAM side comes only from the command register; address/data simply
  // stay on the last command between operations.
  assign bus.mem_address = r_cmd_addr;
  assign bus.mem_data    = r_cmd_wdata;
  assign bus.mem_wren    = (r_state == S_ISSUE) && r_cmd_we;

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.a_gnt  = (r_state != S_IDLE) && !r_cmd_owner;
  assign bus.b_gnt  = (r_state != S_IDLE) &&  r_cmd_owner;
  assign bus.a_done = (r_state == S_RESP) && !r_cmd_owner;
  assign bus.b_done = (r_state == S_RESP) &&  r_cmd_owner;
  assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//  Directed bench for ram_arbiter: one instance at RD_LATENCY=1 and one at
//  RD_LATENCY=3, each with a behavioural single-port RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(5), .DW(8)) bus  ();
  ram_arbiter_if #(.AW(5), .DW(8)) bus3 ();

  ram_arbiter #(.AW(5), .DW(8), .RD_LATENCY(1)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  ram_arbiter #(.AW(5), .DW(8), .RD_LATENCY(3)) u_dut3 (
    .clock (clk),
    .reset (rst),
    .bus   (bus3)
  );

  // RAM models: write on wren, read data delayed by the instance latency.
  logic [7:0] mem1 [32];
  logic [7:0] q1;
  always @(posedge clk) begin
    if (bus.mem_wren) mem1[bus.mem_address] <= bus.mem_data;
    q1 <= mem1[bus.mem_address];
  end
  assign bus.mem_q = q1;

  logic [7:0] mem3 [32];
  logic [7:0] q3 [3];
  always @(posedge clk) begin
    if (bus3.mem_wren) mem3[bus3.mem_address] <= bus3.mem_data;
    q3[0] <= mem3[bus3.mem_address];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign bus3.mem_q = q3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command on instance 1, alone; req raised in an IDLE cycle (cycle 0).
  task automatic run_cmd(input bit who, input bit we, input logic [4:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd,
                         input int exp_cyc, input string tag);
    int  cyc;
    bit  done;
    bit  wren_seen;
    cyc = 0; done = 0; wren_seen = 0;
    if (!who) begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end else begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end
    while (cyc < 20 && !done) begin
      tick();
      cyc++;
      if (bus.mem_wren) wren_seen = 1;
      if (who ? bus.b_done : bus.a_done) done = 1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    if (!we) begin
      check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
      check({tag, "_no_wren"}, 32'(wren_seen), 32'd0);
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    int cyc;
    int overlap;
    bit done;

    rst = 1'b1;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    bus3.a_req = 0; bus3.a_we = 0; bus3.a_addr = 0; bus3.a_wdata = 0;
    bus3.b_req = 0; bus3.b_we = 0; bus3.b_addr = 0; bus3.b_wdata = 0;
    tick();
    tick();

    // Reset state.
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'd0);
    check("rst_done", 32'({bus.a_done, bus.b_done}), 32'd0);
    check("rst_wren", 32'(bus.mem_wren), 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'd0);
    check("rst_data", 32'(bus.mem_data), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_rdata3", 32'(bus3.rdata), 32'd0);

    // 1: A write 3 <= 5A, stepped cycle by cycle.
    rst = 1'b0;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd3; bus.a_wdata = 8'h5A;
    tick();
    check("t1_c1_wren", 32'(bus.mem_wren), 32'd1);
    check("t1_c1_addr", 32'(bus.mem_address), 32'd3);
    check("t1_c1_data", 32'(bus.mem_data), 32'h5A);
    check("t1_c1_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'b10);
    check("t1_c1_done", 32'(bus.a_done), 32'd0);
    tick();
    check("t1_c2_wren", 32'(bus.mem_wren), 32'd0);
    check("t1_c2_done", 32'({bus.a_done, bus.b_done}), 32'b10);
    check("t1_c2_bgnt", 32'(bus.b_gnt), 32'd0);
    bus.a_req = 0;
    tick();
    check("t1_c3_busy", 32'(bus.busy), 32'd0);
    check("t1_c3_done", 32'(bus.a_done), 32'd0);

    // 2: A read 3 -> 5A, done in cycle 3.
    run_cmd(0, 0, 5'd3, 8'h00, 8'h5A, 3, "t2");

    // 3: simultaneous writes after reset; A must win the first tie.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd7; bus.a_wdata = 8'h11;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd9; bus.b_wdata = 8'h22;
    tick();
    check("t3_c1_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'b10);
    check("t3_c1_addr", 32'(bus.mem_address), 32'd7);
    tick();
    check("t3_c2_adone", 32'({bus.a_done, bus.b_done}), 32'b10);
    bus.a_req = 0;
    tick();
    check("t3_c3_idle", 32'(bus.busy), 32'd0);
    tick();
    check("t3_c4_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'b01);
    check("t3_c4_addr", 32'(bus.mem_address), 32'd9);
    check("t3_c4_data", 32'(bus.mem_data), 32'h22);
    tick();
    check("t3_c5_bdone", 32'({bus.a_done, bus.b_done}), 32'b01);
    bus.b_req = 0;
    tick();
    run_cmd(0, 0, 5'd7, 8'h00, 8'h11, 3, "t3_rd7");
    run_cmd(1, 0, 5'd9, 8'h00, 8'h22, 3, "t3_rd9");

    // 4: both held for 8 commands; B served last, so order is A,B,A,B...
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd1; bus.a_wdata = 8'hA1;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd2; bus.b_wdata = 8'hB2;
    k = 0; cyc = 0; overlap = 0;
    while (k < 8 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.a_gnt && bus.b_gnt) overlap++;
      if (bus.a_done || bus.b_done) begin
        check($sformatf("t4_order%0d", k), 32'(bus.b_done), 32'(k % 2));
        if (k == 7) begin
          bus.a_req = 0;
          bus.b_req = 0;
        end
        k++;
      end
    end
    check("t4_count", 32'(k), 32'd8);
    check("t4_overlap", 32'(overlap), 32'd0);
    tick();
    check("t4_rdata_held", 32'(bus.rdata), 32'h22);

    // 5: reset during the WAIT cycle of a B read.
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'd9;
    tick();
    check("t5_issue_gnt", 32'(bus.b_gnt), 32'd1);
    tick();
    check("t5_wait_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'd0);
    check("t5_done", 32'({bus.a_done, bus.b_done}), 32'd0);
    check("t5_mem", 32'({bus.mem_wren, bus.mem_address, bus.mem_data}), 32'd0);
    check("t5_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;
    bus.b_req = 0;
    tick();
    check("t5_no_bdone", 32'(bus.b_done), 32'd0);
    run_cmd(0, 0, 5'd3, 8'h00, 8'h5A, 3, "t5_rd3");

    // 6: RD_LATENCY=3 instance: write 0 <= 3C, then read it back in cycle 5.
    bus3.a_req = 1; bus3.a_we = 1; bus3.a_addr = 5'd0; bus3.a_wdata = 8'h3C;
    cyc = 0; done = 0;
    while (cyc < 20 && !done) begin
      tick();
      cyc++;
      if (bus3.a_done) done = 1;
    end
    check("t6_wr_latency", 32'(cyc), 32'd2);
    bus3.a_req = 0;
    tick();
    bus3.a_req = 1; bus3.a_we = 0; bus3.a_addr = 5'd0;
    cyc = 0; done = 0;
    while (cyc < 20 && !done) begin
      tick();
      cyc++;
      if (bus3.a_done) done = 1;
    end
    check("t6_rd_latency", 32'(cyc), 32'd5);
    check("t6_rdata", 32'(bus3.rdata), 32'h3C);
    bus3.a_req = 0;
    tick();
    check("t6_idle", 32'(bus3.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
